bus_arbiter: RTL and testbench

- Two-master arbiter in front of the shared data Bus (DataMemory below 0x40000000, BCD register at 0x40000010, system counter elsewhere).
- Master 0 is the CPU MEM-stage data port. Master 1 is a DMA/loader engine that fills DataMemory.
- Round-robin grant, bounded ownership (burst limit), optional lock on master 0.
- Registered read-data return per master.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/arb_master_mux.sv | 55 +++++
 rtl/bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus arbiter and the blocks that sit on the
// same bus.
//   arb_state_e : arbiter ownership state (IDLE / OWN0 / OWN1)
//   DMEM_LIMIT  : addresses below this go to DataMemory
//   BCD_ADDR    : address of the BCD display register
//   Any other address at or above DMEM_LIMIT is the system counter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] DMEM_LIMIT = 32'h4000_0000;
    localparam logic [31:0] BCD_ADDR   = 32'h4000_0010;

    function automatic logic is_dmem_addr(input logic [31:0] addr);
        return addr < DMEM_LIMIT;
    endfunction

endpackage

// File: rtl/arb_master_mux.sv
// Combinational steering of the owning master's signals onto the shared bus.
//   state              : current arbiter state (selects the owner)
//   req_x/we_x/re_x... : raw master-side signals
//   bus_*              : bus-side signals; all zero while IDLE
// Strobes are qualified with the owner's request so an owner that has
// already let go of req cannot issue an access in its release cycle.
module arb_master_mux
    import bus_pkg::*;
(
    input  arb_state_e  state,
    input  logic        req_0,
    input  logic        we_0,
    input  logic        re_0,
    input  logic        wob_0,
    input  logic [31:0] addr_0,
    input  logic [31:0] wdata_0,
    input  logic        req_1,
    input  logic        we_1,
    input  logic        re_1,
    input  logic        wob_1,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_1,
    output logic        bus_we,
    output logic        bus_re,
    output logic        bus_wob,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata
);

    always_comb begin
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_wob   = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        case (state)
            OWN0: begin
                bus_we    = we_0 & req_0;
                bus_re    = re_0 & req_0;
                bus_wob   = wob_0;
                bus_addr  = addr_0;
                bus_wdata = wdata_0;
            end
            OWN1: begin
                bus_we    = we_1 & req_1;
                bus_re    = re_1 & req_1;
                bus_wob   = wob_1;
                bus_addr  = addr_1;
                bus_wdata = wdata_1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus.
//   Master 0 : CPU MEM-stage data port (may lock ownership with lock_0)
//   Master 1 : DMA / loader engine
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req_x, lock_0        : ownership request, master-0 preemption lock
//   we_x/re_x/wob_x      : write / read strobes, word-or-byte select
//   addr_x/wdata_x       : byte address, write data
//   gnt_x                : registered grant (decoded from the state register)
//   rdata_x/rvalid_x     : registered read data and its one-cycle valid pulse
//   bus_*                : towards the Bus; bus_rdata is combinational return
// Handshake: a master requests with req_x and may drive strobes only in
// cycles where gnt_x is high; each strobe cycle is one access. A read
// strobed in cycle N returns rdata_x with rvalid_x high in cycle N+1.
// MAX_BURST >= 1 and 2**CNT_W >= MAX_BURST are required.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic        req_1,
    input  logic        lock_0,
    input  logic        we_0,
    input  logic        we_1,
    input  logic        re_0,
    input  logic        re_1,
    input  logic        wob_0,
    input  logic        wob_1,
    input  logic [31:0] addr_0,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_0,
    input  logic [31:0] wdata_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic [31:0] rdata_0,
    output logic [31:0] rdata_1,
    output logic        rvalid_0,
    output logic        rvalid_1,
    output logic        bus_we,
    output logic        bus_re,
    output logic        bus_wob,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    // Count value of the last cycle an owner may keep the bus when contested.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [31:0]      rdata_0_q, rdata_0_d;
    logic [31:0]      rdata_1_q, rdata_1_d;
    logic             rvalid_0_q, rvalid_0_d;
    logic             rvalid_1_q, rvalid_1_d;

    logic             mux_we;
    logic             mux_re;

    arb_master_mux u_mux (
        .state     (state_q),
        .req_0     (req_0),
        .we_0      (we_0),
        .re_0      (re_0),
        .wob_0     (wob_0),
        .addr_0    (addr_0),
        .wdata_0   (wdata_0),
        .req_1     (req_1),
        .we_1      (we_1),
        .re_1      (re_1),
        .wob_1     (wob_1),
        .addr_1    (addr_1),
        .wdata_1   (wdata_1),
        .bus_we    (mux_we),
        .bus_re    (mux_re),
        .bus_wob   (bus_wob),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata)
    );

    // No access may reach the bus in a reset cycle, even though the state
    // register still shows an owner until the edge.
    assign bus_we = mux_we & ~reset;
    assign bus_re = mux_re & ~reset;

    assign gnt_0    = (state_q == OWN0);
    assign gnt_1    = (state_q == OWN1);
    assign rdata_0  = rdata_0_q;
    assign rdata_1  = rdata_1_q;
    assign rvalid_0 = rvalid_0_q;
    assign rvalid_1 = rvalid_1_q;

    // Ownership FSM next state.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                // On a tie the master that did not own last goes first.
                if (req_0 && (!req_1 || last_owner_q)) begin
                    state_d      = OWN0;
                    last_owner_d = 1'b0;
                    burst_cnt_d  = '0;
                end else if (req_1) begin
                    state_d      = OWN1;
                    last_owner_d = 1'b1;
                    burst_cnt_d  = '0;
                end
            end
            OWN0: begin
                if (!req_0 || (burst_cnt_q == BURST_LAST && req_1 && !lock_0)) begin
                    if (req_1) begin
                        state_d      = OWN1;
                        last_owner_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                    burst_cnt_d = '0;
                end else if (burst_cnt_q != BURST_LAST) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            OWN1: begin
                if (!req_1 || (burst_cnt_q == BURST_LAST && req_0)) begin
                    if (req_0) begin
                        state_d      = OWN0;
                        last_owner_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                    burst_cnt_d = '0;
                end else if (burst_cnt_q != BURST_LAST) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Read capture: the owner's read data is sampled at the edge that ends
    // the strobe cycle; the holding register keeps its value otherwise.
    always_comb begin
        rvalid_0_d = (state_q == OWN0) && re_0 && req_0;
        rvalid_1_d = (state_q == OWN1) && re_1 && req_1;
        rdata_0_d  = rvalid_0_d ? bus_rdata : rdata_0_q;
        rdata_1_d  = rvalid_1_d ? bus_rdata : rdata_1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            rdata_0_q    <= 32'h0;
            rdata_1_q    <= 32'h0;
            rvalid_0_q   <= 1'b0;
            rvalid_1_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rdata_0_q    <= rdata_0_d;
            rdata_1_q    <= rdata_1_d;
            rvalid_0_q   <= rvalid_0_d;
            rvalid_1_q   <= rvalid_1_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a small word memory stands in for the Bus, a
// cycle-level ownership model predicts grants, bus outputs and read returns.
module tb_bus_arbiter;

    localparam int MAX_BURST = 8;
    localparam logic [31:0] BCD = 32'h4000_0010;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_0, req_1, lock_0;
    logic        we_0, we_1, re_0, re_1, wob_0, wob_1;
    logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [31:0] rdata_0, rdata_1;
    logic        bus_we, bus_re, bus_wob;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    bus_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .req_1(req_1), .lock_0(lock_0),
        .we_0(we_0), .we_1(we_1), .re_0(re_0), .re_1(re_1),
        .wob_0(wob_0), .wob_1(wob_1),
        .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .bus_we(bus_we), .bus_re(bus_re), .bus_wob(bus_wob),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    // ---------------- bus stand-in ----------------
    logic [31:0] mem [256] = '{default: 32'h0};

    function automatic logic [7:0] mem_idx(input logic [31:0] a);
        return {a[30], a[8:2]};
    endfunction

    assign bus_rdata = mem[mem_idx(bus_addr)];
    always @(posedge clk) if (bus_we) mem[mem_idx(bus_addr)] <= bus_wdata;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 none, else master index; run: cycles held so far by owner.
    int          m_owner, m_last, m_run;
    logic [31:0] m_rdata [2];
    logic        m_rvalid [2];

    // One clock cycle with the currently driven inputs: checks the bus side
    // before the edge, then grants and read returns after it.
    task automatic run_cycle();
        logic [31:0] e_addr, e_wdata, rv;
        logic        e_we, e_re, e_wob, rd0, rd1, was_rst;
        logic        rq [2];
        int          nxt, x, o;
        #1;
        rq[0] = req_0; rq[1] = req_1;
        was_rst = reset;
        e_we = 0; e_re = 0; e_wob = 0; e_addr = 0; e_wdata = 0;
        if (m_owner == 0) begin
            e_we = we_0 & req_0; e_re = re_0 & req_0; e_wob = wob_0;
            e_addr = addr_0; e_wdata = wdata_0;
        end else if (m_owner == 1) begin
            e_we = we_1 & req_1; e_re = re_1 & req_1; e_wob = wob_1;
            e_addr = addr_1; e_wdata = wdata_1;
        end
        if (was_rst) begin e_we = 0; e_re = 0; end
        chk1("bus_we", bus_we, e_we);
        chk1("bus_re", bus_re, e_re);
        chk1("bus_wob", bus_wob, e_wob);
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wdata", bus_wdata, e_wdata);

        rd0 = (m_owner == 0) && re_0 && req_0 && !was_rst;
        rd1 = (m_owner == 1) && re_1 && req_1 && !was_rst;
        rv  = mem[mem_idx(e_addr)];
        if (rd0) exp_q0.push_back(rv);
        if (rd1) exp_q1.push_back(rv);

        if (was_rst) begin
            m_owner = -1; m_last = 1; m_run = 0;
        end else if (m_owner < 0) begin
            nxt = -1;
            if (rq[0] && rq[1]) nxt = 1 - m_last;
            else if (rq[0]) nxt = 0;
            else if (rq[1]) nxt = 1;
            if (nxt >= 0) begin m_owner = nxt; m_last = nxt; m_run = 1; end
        end else begin
            x = m_owner; o = 1 - x;
            if (!rq[x]) begin
                if (rq[o]) begin m_owner = o; m_last = o; m_run = 1; end
                else m_owner = -1;
            end else if (m_run >= MAX_BURST && rq[o] && !(x == 0 && lock_0)) begin
                m_owner = o; m_last = o; m_run = 1;
            end else begin
                m_run++;
            end
        end

        @(posedge clk);
        #1;
        m_rvalid[0] = rd0;
        m_rvalid[1] = rd1;
        if (was_rst) begin m_rdata[0] = 0; m_rdata[1] = 0; end
        if (rd0) m_rdata[0] = rv;
        if (rd1) m_rdata[1] = rv;

        chk1("gnt_0", gnt_0, m_owner == 0);
        chk1("gnt_1", gnt_1, m_owner == 1);
        chk1("gnt_exclusive", gnt_0 & gnt_1, 1'b0);
        chk1("rvalid_0", rvalid_0, m_rvalid[0]);
        chk1("rvalid_1", rvalid_1, m_rvalid[1]);
        if (m_rvalid[0]) chk("rdata_0_return", rdata_0, exp_q0.pop_front());
        if (m_rvalid[1]) chk("rdata_1_return", rdata_1, exp_q1.pop_front());
        chk("rdata_0_hold", rdata_0, m_rdata[0]);
        chk("rdata_1_hold", rdata_1, m_rdata[1]);
    endtask

    // ---------------- driver helpers ----------------
    task automatic clear_strobes();
        we_0 = 0; re_0 = 0; wob_0 = 0; addr_0 = 0; wdata_0 = 0;
        we_1 = 0; re_1 = 0; wob_1 = 0; addr_1 = 0; wdata_1 = 0;
    endtask

    typedef struct {
        logic r0, r1;
        logic g0, g1;
    } vec_t;

    vec_t        tie_tab [7];
    logic [31:0] addr_pool [4];

    initial begin
        int burst_len;

        tie_tab[0] = '{1, 1, 1, 0};
        tie_tab[1] = '{1, 1, 1, 0};
        tie_tab[2] = '{0, 1, 0, 1};
        tie_tab[3] = '{0, 1, 0, 1};
        tie_tab[4] = '{0, 0, 0, 0};
        tie_tab[5] = '{1, 1, 1, 0};
        tie_tab[6] = '{0, 0, 0, 0};
        addr_pool[0] = 32'h0000_0100;
        addr_pool[1] = 32'h0000_0104;
        addr_pool[2] = BCD;
        addr_pool[3] = 32'h0000_0200;

        reset = 1; req_0 = 0; req_1 = 0; lock_0 = 0;
        clear_strobes();
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_gnt_0", gnt_0, 1'b0);
        chk1("reset_gnt_1", gnt_1, 1'b0);
        chk1("reset_rvalid_0", rvalid_0, 1'b0);
        chk1("reset_rvalid_1", rvalid_1, 1'b0);
        chk("reset_rdata_0", rdata_0, 32'h0);
        chk("reset_rdata_1", rdata_1, 32'h0);
        chk1("reset_bus_we", bus_we, 1'b0);
        m_owner = -1; m_last = 1; m_run = 0;
        m_rdata[0] = 0; m_rdata[1] = 0; m_rvalid[0] = 0; m_rvalid[1] = 0;
        reset = 0;

        // Single requester: write then read back.
        req_0 = 1;
        run_cycle();
        chk1("single_gnt", gnt_0, 1'b1);
        we_0 = 1; addr_0 = 32'h100; wdata_0 = 32'hDEAD_BEEF;
        run_cycle();
        we_0 = 0; re_0 = 1;
        run_cycle();
        chk1("single_rvalid", rvalid_0, 1'b1);
        chk("single_rdata", rdata_0, 32'hDEAD_BEEF);
        re_0 = 0;
        run_cycle();
        chk1("single_rvalid_pulse", rvalid_0, 1'b0);
        req_0 = 0;
        run_cycle();

        // Reset pulse, then tie resolution table.
        reset = 1;
        run_cycle();
        reset = 0;
        foreach (tie_tab[i]) begin
            req_0 = tie_tab[i].r0;
            req_1 = tie_tab[i].r1;
            run_cycle();
            chk1("tie_gnt_0", gnt_0, tie_tab[i].g0);
            chk1("tie_gnt_1", gnt_1, tie_tab[i].g1);
        end

        // Burst limit: master 1 owns, master 0 contends continuously.
        req_1 = 1; req_0 = 0;
        run_cycle();
        chk1("burst_start", gnt_1, 1'b1);
        req_0 = 1;
        burst_len = 1;
        for (int k = 0; k < 20 && gnt_1; k++) begin
            run_cycle();
            if (gnt_1) burst_len++;
        end
        chk("burst_len", burst_len, MAX_BURST);
        chk1("burst_handover", gnt_0, 1'b1);

        // Lock with a contending, misbehaving master 1 on the BCD register.
        lock_0 = 1;
        we_1 = 1; addr_1 = BCD; wdata_1 = 32'hBAD0_BAD0;
        for (int k = 0; k < 20; k++) begin
            we_0 = (k == 0); re_0 = (k == 1);
            addr_0 = BCD; wdata_0 = 32'h0000_1234;
            run_cycle();
            chk1("lock_hold", gnt_0, 1'b1);
            if (k == 1) begin
                chk1("bcd_rvalid", rvalid_0, 1'b1);
                chk("bcd_rdata", rdata_0, 32'h0000_1234);
            end
        end
        we_0 = 0; re_0 = 0;
        chk("bcd_isolated", mem[mem_idx(BCD)], 32'h0000_1234);
        lock_0 = 0;
        run_cycle();
        chk1("lock_release", gnt_1, 1'b1);
        clear_strobes();

        // Reset in the same cycle as a master 0 read and write.
        req_1 = 0;
        run_cycle();
        chk1("release_to_0", gnt_0, 1'b1);
        re_0 = 1; we_0 = 1; addr_0 = 32'h100; wdata_0 = 32'h5555_5555;
        reset = 1;
        run_cycle();
        chk1("rst_mid_gnt_0", gnt_0, 1'b0);
        chk1("rst_mid_rvalid", rvalid_0, 1'b0);
        chk("rst_mid_no_write", mem[mem_idx(32'h100)], 32'hDEAD_BEEF);
        reset = 0; clear_strobes();
        req_0 = 1; req_1 = 1;
        run_cycle();
        chk1("post_reset_tie", gnt_0, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset   = ($urandom_range(0, 49) == 0);
            req_0   = ($urandom_range(0, 3) != 0);
            req_1   = ($urandom_range(0, 3) != 0);
            lock_0  = ($urandom_range(0, 4) == 0);
            we_0    = ($urandom_range(0, 3) == 0);
            we_1    = ($urandom_range(0, 3) == 0);
            re_0    = ($urandom_range(0, 1) == 0);
            re_1    = ($urandom_range(0, 1) == 0);
            wob_0   = 1'($urandom_range(0, 1));
            wob_1   = 1'($urandom_range(0, 1));
            addr_0  = addr_pool[$urandom_range(0, 3)];
            addr_1  = addr_pool[$urandom_range(0, 3)];
            wdata_0 = $urandom;
            wdata_1 = $urandom;
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
